// File: rtl/nv_buf_rr_arb_pkg.sv
// Shared constants and types for the round-robin packet arbiter and its
// two-entry output buffer.
package nv_buf_rr_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DW_DEF      = 32;
    localparam int IDX_W       = $clog2(NUM_REQ_DEF);

    // IDLE: no packet owner. LOCKED: owner keeps the grant until its last beat.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Buffer entry layout at the default widths: payload, last flag, source.
    typedef struct packed {
        logic [DW_DEF-1:0] pd;
        logic              last;
        logic [IDX_W-1:0]  src;
    } buf_entry_t;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nv_buf_skid2.sv
// Two-entry FIFO between the arbiter and the output port. Registered-full:
// a push is only accepted while fewer than two entries are held, even if the
// head is being popped in the same cycle.
module nv_buf_skid2
    import nv_buf_rr_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         not_empty,
    output logic         full
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         push_en;
    logic         pop_en;

    assign push_en   = push && (count_reg != 2'd2);
    assign pop_en    = pop && (count_reg != 2'd0);
    assign head_data = mem_reg[rd_ptr_reg];
    assign not_empty = (count_reg != 2'd0);
    assign full      = (count_reg == 2'd2);

    // Pointer and occupancy bookkeeping; reset empties the buffer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/nv_buf_rr_arb.sv
// Round-robin packet arbiter: picks one requester per packet, holds the
// grant until the last beat, and queues accepted beats in a 2-entry buffer.
module nv_buf_rr_arb
    import nv_buf_rr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DW-1:0]        req_pd,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_pd,
    output logic                         out_last,
    output logic [idx_width(NUM_REQ)-1:0] out_src,
    input  logic                         cfg_enable,
    input  logic [NUM_REQ-1:0]           cfg_mask,
    input  logic                         cfg_cnt_clr,
    output logic [15:0]                  grant_cnt
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int EW = DW + 1 + IW;

    arb_state_t    state_reg;
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] owner_reg;
    logic [15:0]   grant_cnt_reg;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic          buf_full;
    logic          acc;
    logic          acc_last;
    logic [DW-1:0] acc_pd;
    logic [IW-1:0] rr_ptr_next;
    logic [EW-1:0] head_entry;

    // Rotating search from rr_ptr for the first valid, unmasked requester.
    always_comb begin
        logic [IW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!win_found && req_valid[cand] && !cfg_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A locked owner keeps its grant regardless of enable/mask; new grants
    // need enable. Nothing is granted while the buffer is full or in reset.
    assign grant_idx = (state_reg == LOCKED) ? owner_reg : win_idx;
    assign grant_any = !nvdla_core_rst && !buf_full &&
                       ((state_reg == LOCKED) || (cfg_enable && win_found));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (grant_idx == IW'(gi));
        end
    endgenerate

    assign acc         = |(req_valid & req_ready);
    assign acc_last    = req_last[grant_idx];
    assign acc_pd      = req_pd[int'(grant_idx)*DW +: DW];
    assign rr_ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Packet lock FSM and round-robin pointer, advanced on accepted beats.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else if (acc) begin
            if (acc_last) begin
                state_reg  <= IDLE;
                rr_ptr_reg <= rr_ptr_next;
            end else if (state_reg == IDLE) begin
                state_reg <= LOCKED;
                owner_reg <= grant_idx;
            end
        end
    end

    // Completed-packet counter: saturating, with clear taking priority.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            grant_cnt_reg <= 16'd0;
        end else if (cfg_cnt_clr) begin
            grant_cnt_reg <= 16'd0;
        end else if (acc && acc_last && (grant_cnt_reg != 16'hFFFF)) begin
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_reg;

    nv_buf_skid2 #(
        .W (EW)
    ) u_skid2 (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .push      (acc),
        .push_data ({acc_pd, acc_last, grant_idx}),
        .pop       (out_valid && out_ready),
        .head_data (head_entry),
        .not_empty (out_valid),
        .full      (buf_full)
    );

    assign out_pd   = head_entry[EW-1 -: DW];
    assign out_last = head_entry[IW];
    assign out_src  = head_entry[IW-1:0];

endmodule

// File: tb/tb_nv_buf_rr_arb.sv
// Directed bench for nv_buf_rr_arb: round-robin order, packet locking,
// back-pressure, masking/enable, counter saturation/clear and reset.
module tb_nv_buf_rr_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_pd;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pd;
    logic         out_last;
    logic [1:0]   out_src;
    logic         cfg_enable;
    logic [3:0]   cfg_mask;
    logic         cfg_cnt_clr;
    logic [15:0]  grant_cnt;

    int checks = 0;
    int errors = 0;

    nv_buf_rr_arb dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_pd         (req_pd),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pd         (out_pd),
        .out_last       (out_last),
        .out_src        (out_src),
        .cfg_enable     (cfg_enable),
        .cfg_mask       (cfg_mask),
        .cfg_cnt_clr    (cfg_cnt_clr),
        .grant_cnt      (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task step;
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task settle;
        #1;
    endtask

    task set_pd(input int i, input logic [31:0] v);
        req_pd[i*32 +: 32] = v;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 4'h0;
        req_last    = 4'h0;
        req_pd      = '0;
        out_ready   = 1'b0;
        cfg_enable  = 1'b1;
        cfg_mask    = 4'h0;
        cfg_cnt_clr = 1'b0;

        // Reset state, with requests already pending.
        req_valid = 4'hF;
        step;
        step;
        settle;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cnt", 32'(grant_cnt), 32'h0);
        req_valid = 4'h0;
        rst = 1'b0;
        step;

        // Four requesters, single-beat packets, full throughput.
        for (int i = 0; i < 4; i++) set_pd(i, 32'h100 + i);
        req_last  = 4'hF;
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            settle;
            chk("s1_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("s1_src", 32'(out_src), 32'((k - 1) % 4));
                chk("s1_pd", out_pd, 32'h100 + 32'((k - 1) % 4));
            end
            step;
        end
        req_valid = 4'h0;
        settle;
        chk("s1_src_last", 32'(out_src), 32'd3);
        chk("s1_cnt", 32'(grant_cnt), 32'd8);
        step;
        settle;
        chk("s1_drained", 32'(out_valid), 32'h0);

        // Req1 three-beat packet while req2 waits (rr_ptr = 0).
        set_pd(1, 32'h11);
        set_pd(2, 32'h22);
        req_last  = 4'b0100;
        req_valid = 4'b0110;
        settle;
        chk("s2_ready0", 32'(req_ready), 32'h2);
        step;
        set_pd(1, 32'h12);
        settle;
        chk("s2_ready1", 32'(req_ready), 32'h2);
        chk("s2_src1", 32'(out_src), 32'd1);
        chk("s2_pd1", out_pd, 32'h11);
        chk("s2_last1", 32'(out_last), 32'd0);
        step;
        set_pd(1, 32'h13);
        req_last = 4'b0110;
        settle;
        chk("s2_ready2", 32'(req_ready), 32'h2);
        chk("s2_pd2", out_pd, 32'h12);
        step;
        req_valid = 4'b0100;
        settle;
        chk("s2_req2_grant", 32'(req_ready), 32'h4);
        chk("s2_pd3", out_pd, 32'h13);
        chk("s2_last3", 32'(out_last), 32'd1);
        step;
        req_valid = 4'h0;
        settle;
        chk("s2_src_req2", 32'(out_src), 32'd2);
        chk("s2_pd_req2", out_pd, 32'h22);
        chk("s2_cnt", 32'(grant_cnt), 32'd10);
        step;

        // Back-pressure: three beats offered with out_ready low (rr_ptr = 3).
        out_ready = 1'b0;
        set_pd(0, 32'h30);
        req_last  = 4'h0;
        req_valid = 4'b0001;
        settle;
        chk("s3_ready0", 32'(req_ready), 32'h1);
        step;
        set_pd(0, 32'h31);
        settle;
        chk("s3_ready1", 32'(req_ready), 32'h1);
        chk("s3_valid1", 32'(out_valid), 32'd1);
        chk("s3_pd1", out_pd, 32'h30);
        step;
        set_pd(0, 32'h32);
        req_last = 4'b0001;
        settle;
        chk("s3_full_ready", 32'(req_ready), 32'h0);
        chk("s3_full_pd", out_pd, 32'h30);
        step;
        settle;
        chk("s3_hold_pd", out_pd, 32'h30);
        out_ready = 1'b1;
        settle;
        chk("s3_full_ordy", 32'(req_ready), 32'h0);
        step;
        settle;
        chk("s3_drain_pd1", out_pd, 32'h31);
        chk("s3_ready3", 32'(req_ready), 32'h1);
        step;
        req_valid = 4'h0;
        settle;
        chk("s3_drain_pd2", out_pd, 32'h32);
        chk("s3_drain_last", 32'(out_last), 32'd1);
        step;
        settle;
        chk("s3_empty", 32'(out_valid), 32'd0);
        chk("s3_cnt", 32'(grant_cnt), 32'd11);

        // Mask and disable while req1 is locked (rr_ptr = 1).
        set_pd(1, 32'h41);
        req_last  = 4'h0;
        req_valid = 4'b0010;
        settle;
        chk("s4_ready0", 32'(req_ready), 32'h2);
        step;
        cfg_mask   = 4'b0010;
        cfg_enable = 1'b0;
        set_pd(1, 32'h42);
        req_last = 4'b0010;
        settle;
        chk("s4_locked_ready", 32'(req_ready), 32'h2);
        chk("s4_pd41", out_pd, 32'h41);
        step;
        cfg_enable = 1'b1;
        settle;
        chk("s4_masked", 32'(req_ready), 32'h0);
        cfg_enable = 1'b0;
        req_valid  = 4'hF;
        req_last   = 4'hF;
        settle;
        chk("s4_disabled", 32'(req_ready), 32'h0);
        cfg_enable = 1'b1;
        req_valid  = 4'b0011;
        set_pd(0, 32'h50);
        settle;
        chk("s4_rr_skip", 32'(req_ready), 32'h1);
        chk("s4_pd42", out_pd, 32'h42);
        step;
        req_valid = 4'h0;
        cfg_mask  = 4'h0;
        settle;
        chk("s4_pd50", out_pd, 32'h50);
        chk("s4_src0", 32'(out_src), 32'd0);
        chk("s4_cnt", 32'(grant_cnt), 32'd13);
        step;

        // Counter clear, saturation, and clear winning over an increment.
        cfg_cnt_clr = 1'b1;
        step;
        cfg_cnt_clr = 1'b0;
        settle;
        chk("s5_clr", 32'(grant_cnt), 32'h0);
        req_valid = 4'hF;
        req_last  = 4'hF;
        repeat (65535) step;
        settle;
        chk("s5_max", 32'(grant_cnt), 32'hFFFF);
        step;
        settle;
        chk("s5_sat", 32'(grant_cnt), 32'hFFFF);
        cfg_cnt_clr = 1'b1;
        step;
        cfg_cnt_clr = 1'b0;
        req_valid   = 4'h0;
        settle;
        chk("s5_clr_wins", 32'(grant_cnt), 32'h0);
        step;

        // Reset mid-packet with two beats buffered.
        out_ready = 1'b0;
        req_last  = 4'h0;
        req_valid = 4'b0100;
        set_pd(2, 32'h60);
        settle;
        step;
        set_pd(2, 32'h61);
        step;
        settle;
        chk("s6_full_valid", 32'(out_valid), 32'd1);
        chk("s6_full_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        settle;
        chk("s6_rst_valid", 32'(out_valid), 32'd0);
        chk("s6_rst_ready", 32'(req_ready), 32'h0);
        chk("s6_rst_cnt", 32'(grant_cnt), 32'h0);
        step;
        rst       = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        set_pd(0, 32'h70);
        out_ready = 1'b1;
        settle;
        chk("s6_first_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 4'h0;
        settle;
        chk("s6_out_src", 32'(out_src), 32'd0);
        chk("s6_out_pd", out_pd, 32'h70);
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_buf_rr_arb.md
NV_BUF_RR_ARB -- requirements
Module: nv_buf_rr_arb

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; DW, default 32, payload width.
REQ-002 Ports SHALL be (name direction width meaning):
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last beat of packet.
- req_pd  in  NUM_REQ*DW  per-requester payload; requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ  per-requester accept.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_pd  out  DW  output payload.
- out_last  out  1  output last beat.
- out_src  out  clog2(NUM_REQ)  source index of output beat.
- cfg_enable  in  1  permits new packet grants.
- cfg_mask  in  NUM_REQ  1 excludes requester from new grants.
- cfg_cnt_clr  in  1  synchronous clear of grant_cnt.
- grant_cnt  out  16  completed-packet count.

Function
REQ-003 A beat SHALL transfer on a port only when valid and ready are both 1 in the same cycle.
REQ-004 Requesters SHALL hold req_valid, req_pd and req_last stable until accepted; the block SHALL NOT depend on them otherwise.
REQ-005 The arbiter FSM SHALL have two states: IDLE (no packet owner) and LOCKED (owner holds grant mid-packet).
REQ-006 In IDLE, with cfg_enable=1 and buffer count<2, the winner SHALL be the first requester i with req_valid[i]=1 and cfg_mask[i]=0, searched from rr_ptr upward modulo NUM_REQ.
REQ-007 req_ready SHALL be combinational, with at most one bit set, and SHALL equal the winner (IDLE) or owner (LOCKED) one-hot, gated by count<2.
REQ-008 In IDLE, an accepted beat with last=0 SHALL move the FSM to LOCKED with owner=winner.
REQ-009 An accepted beat with last=1 SHALL move the FSM to or stay in IDLE, and SHALL set rr_ptr=(source+1) mod NUM_REQ.
REQ-010 In LOCKED, only the owner SHALL be granted; cfg_enable=0 or cfg_mask[owner]=1 SHALL NOT abort the packet.
REQ-011 With cfg_enable=0 in IDLE, all req_ready SHALL be 0.
REQ-012 The output buffer SHALL be a 2-entry FIFO storing {pd, last, src}.
- push = any req handshake; pop = out_valid & out_ready.
- Push and pop SHALL be allowed in the same cycle.
- No same-cycle bypass: an accepted beat SHALL appear on out_* exactly one cycle later at the earliest.
REQ-013 out_valid SHALL be 1 iff count!=0; out_pd, out_last and out_src SHALL reflect the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-014 At count=2, all req_ready SHALL be 0, including when out_ready=1 (registered-full behaviour).
REQ-015 grant_cnt SHALL increment on each accepted last=1 beat and saturate at 0xFFFF; cfg_cnt_clr SHALL force 0 and win over a simultaneous increment.
REQ-016 Beat order at the output SHALL equal acceptance order; beats of different packets SHALL never interleave.

Reset
REQ-017 Asserting nvdla_core_rst SHALL immediately set: FSM=IDLE, rr_ptr=0, owner=0, count=0, out_valid=0, req_ready=0, grant_cnt=0.
REQ-018 Reset mid-packet SHALL discard buffered beats and the lock; after deassertion, arbitration SHALL restart from requester 0.

Structure
REQ-019 Package nv_buf_rr_arb_pkg SHALL hold the NUM_REQ/DW defaults, the index width constant, the FSM state enum {IDLE, LOCKED} and the buffer-entry struct.
REQ-020 The 2-entry FIFO SHALL be the sub-module nv_buf_skid2; arbitration, FSM and counter SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- All 4 requesters send single-beat packets continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,...; grant_cnt=8 after 8 beats.
- Req1 sends a 3-beat packet while req2 is valid -> out_src 1,1,1 then 2; req2 is not granted before req1's last beat.
- out_ready=0 with 3 beats offered -> count reaches 2, req_ready=0, out_pd holds the first beat; out_ready=1 -> drains in order.
- cfg_mask=4'b0010 or cfg_enable=0 asserted while req1 is LOCKED -> req1 packet completes; in IDLE, req1 is never granted and cfg_enable=0 gives no grants.
- grant_cnt preloaded to 0xFFFF then one packet completes -> stays 0xFFFF; cfg_cnt_clr on the same cycle as a completion -> 0.
- Reset asserted mid-packet with 2 beats buffered -> out_valid=0 and req_ready=0 immediately; after release, the first grant goes to requester 0.
